issue_credit_alloc: RTL and testbench

ISSUE_CREDIT_ALLOC -- requirements
Module: issue_credit_alloc

---
 rtl/issue_credit_alloc.sv | 58 +++++
 tb/tb_issue_credit_alloc.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/issue_credit_alloc.sv
// issue_credit_alloc: in-order issue-queue slot allocator with free-slot credits and delayed upstream backpressure
module issue_credit_alloc #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 2,
  parameter int THRESH = 4,
  parameter int DELAY  = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             snoop_hit,
  input  logic [WIDTH-1:0] i_valid,
  input  logic [CW-1:0]    i_release,
  output logic             o_readyn,
  output logic [WIDTH-1:0] next_wen,
  output logic [CW-1:0]    o_free,
  output logic             o_overflow
);
  logic [CW-1:0]    free_q, free_d;
  logic [DELAY-1:0] dly_q, dly_d;
  logic             ovf_q, ovf_d;
  logic             raw, gate, run, over;
  logic [CW-1:0]    g;
  logic [CW:0]      sum;
  // Everything below is driven from registered state and i_valid only, so
  // release and snoop never reach the grant or readyn outputs in the same cycle.
  always_comb begin
    raw      = free_q <= CW'(THRESH);
    gate     = dly_q[DELAY-1];
    o_readyn = raw | (|dly_q);
    next_wen = '0;
    g        = '0;
    run      = ~gate;
    for (int k = 0; k < WIDTH; k++) begin
      run         = run & i_valid[k];
      next_wen[k] = run & (CW'(k) < free_q);
      g           = g + CW'(next_wen[k]);
    end
    sum    = {1'b0, free_q} - (CW+1)'(g) + {1'b0, i_release};
    over   = sum > (CW+1)'(DEPTH);
    free_d = over ? CW'(DEPTH) : sum[CW-1:0];
    ovf_d  = ovf_q | over;
    dly_d  = snoop_hit ? {DELAY{1'b1}} : ((dly_q << 1) | DELAY'(raw));
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      free_q <= CW'(DEPTH);
      dly_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      free_q <= free_d;
      dly_q  <= dly_d;
      ovf_q  <= ovf_d;
    end
  end
  assign o_free     = free_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_issue_credit_alloc.sv
// tb_issue_credit_alloc: directed vectors with hand-computed expectations for issue_credit_alloc
module tb_issue_credit_alloc;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       snoop_hit = 1'b0;
  logic [1:0] i_valid = '0;
  logic [4:0] i_release = '0;
  logic       o_readyn;
  logic [1:0] next_wen;
  logic [4:0] o_free;
  logic       o_overflow;
  int n_cmp = 0;
  int n_bad = 0;

  issue_credit_alloc #(.DEPTH(16), .WIDTH(2), .THRESH(4), .DELAY(4)) dut (
    .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit), .i_valid(i_valid),
    .i_release(i_release), .o_readyn(o_readyn), .next_wen(next_wen),
    .o_free(o_free), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] rel, input logic sn);
    i_valid = v;
    i_release = rel;
    snoop_hit = sn;
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    i_valid = '0;
    i_release = '0;
    snoop_hit = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  int ef[10] = '{16, 14, 12, 10, 8, 6, 4, 2, 0, 0};
  int ew[10] = '{3, 3, 3, 3, 3, 3, 3, 3, 0, 0};

  initial begin
    do_reset();
    drive(2'b00, 5'd0, 1'b0);
    chk("rst_free", o_free, 16);
    chk("rst_readyn", o_readyn, 0);
    chk("rst_wen", next_wen, 0);
    chk("rst_ovf", o_overflow, 0);

    for (int c = 0; c < 10; c++) begin
      drive(2'b11, 5'd0, 1'b0);
      chk($sformatf("fill_free_%0d", c), o_free, ef[c]);
      chk($sformatf("fill_wen_%0d", c), next_wen, ew[c]);
      chk($sformatf("fill_readyn_%0d", c), o_readyn, c >= 6 ? 1 : 0);
      tick();
    end

    do_reset();
    drive(2'b10, 5'd0, 1'b0);
    chk("inorder_wen", next_wen, 0);
    tick();
    chk("inorder_free", o_free, 16);
    drive(2'b01, 5'd0, 1'b0);
    chk("lane0_wen", next_wen, 1);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(2'b11, 5'd0, 1'b0);
      tick();
    end
    chk("pre_sim_free", o_free, 5);
    drive(2'b11, 5'd2, 1'b0);
    chk("sim_wen", next_wen, 3);
    tick();
    chk("sim_free", o_free, 5);
    drive(2'b11, 5'd0, 1'b0);
    tick();
    chk("to3_free", o_free, 3);
    chk("to3_readyn", o_readyn, 1);
    chk("to3_wen", next_wen, 3);
    tick();
    chk("part_free", o_free, 1);
    chk("part_wen", next_wen, 1);
    tick();
    chk("part_free_after", o_free, 0);
    chk("part_wen_after", next_wen, 0);

    do_reset();
    drive(2'b11, 5'd0, 1'b1);
    chk("snp_n_wen", next_wen, 3);
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(2'b11, 5'd0, 1'b0);
      chk($sformatf("snp_readyn_n%0d", c), o_readyn, 1);
      chk($sformatf("snp_wen_n%0d", c), next_wen, 0);
      chk($sformatf("snp_free_n%0d", c), o_free, 14);
      tick();
    end
    drive(2'b11, 5'd0, 1'b0);
    chk("snp_resume_wen", next_wen, 3);
    chk("snp_resume_readyn", o_readyn, 0);

    do_reset();
    for (int c = 0; c <= 7; c++) begin
      drive(2'b11, 5'd0, (c == 0 || c == 2) ? 1'b1 : 1'b0);
      if (c >= 1 && c <= 6) begin
        chk($sformatf("snp2_readyn_n%0d", c), o_readyn, 1);
        chk($sformatf("snp2_wen_n%0d", c), next_wen, 0);
      end
      if (c == 7) begin
        chk("snp2_resume_wen", next_wen, 3);
        chk("snp2_resume_readyn", o_readyn, 0);
      end
      tick();
    end

    drive(2'b00, 5'd0, 1'b1);
    tick();
    do_reset();
    drive(2'b11, 5'd0, 1'b0);
    chk("midrst_readyn", o_readyn, 0);
    chk("midrst_wen", next_wen, 3);
    chk("midrst_free", o_free, 16);

    do_reset();
    drive(2'b01, 5'd0, 1'b0);
    tick();
    chk("ovf_pre_free", o_free, 15);
    drive(2'b00, 5'd3, 1'b0);
    tick();
    chk("ovf_free", o_free, 16);
    chk("ovf_flag", o_overflow, 1);
    drive(2'b11, 5'd0, 1'b1);
    tick();
    drive(2'b00, 5'd2, 1'b0);
    tick();
    chk("ovf_sticky", o_overflow, 1);
    do_reset();
    drive(2'b00, 5'd0, 1'b0);
    chk("ovf_cleared", o_overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
